alu_req_master: RTL and testbench
=================================

// Module: alu_req_master
// PURPOSE
//  Initiator side of the ALU pin interface. Accepts one operation at a time on a
//  valid/ready request channel and drives CE/MODE/CMD/OPA/OPB/CIN/INP_VALID into the ALU.
//  Waits the command-dependent ALU latency, captures RES and the flags, and returns them
//  on a valid/ready response channel.
//  Sits between the stimulus/software layer and the ALU core; one transaction is in flight at a time.
// PARAMETERS
//  WIDTH        8   operand width; RES is WIDTH+1 bits
//  CMD_WIDTH    4   command field width
//  DEF_LAT      1   ALU result latency (cycles) for all commands except multiply
//  MUL_LAT      3   ALU result latency for MODE=1, CMD=9 or CMD=10 (multiply variants)
// PORTS
//  CLK        in   1           clock, all state on posedge
//  RST        in   1           asynchronous, active-low reset
//  req_valid  in   1           request present
//  req_ready  out  1           master idle, accepts request
//  req_mode   in   1           1=arithmetic, 0=logical
//  req_cmd    in   CMD_WIDTH   ALU command
//  req_opa    in   WIDTH       operand A
//  req_opb    in   WIDTH       operand B
//  req_cin    in   1           carry in
//  req_split  in   1           1: send OPA and OPB in separate beats (INP_VALID 01 then 10)
//  CE         out  1           ALU clock enable
//  MODE       out  1           to ALU
//  CMD        out  CMD_WIDTH   to ALU
//  OPA, OPB   out  WIDTH       to ALU
//  CIN        out  1           to ALU
//  INP_VALID  out  2           to ALU operand-valid code
//  RES        in   WIDTH+1     ALU result
//  COUT, OFLOW, ERR, G, L, E  in  1 each  ALU flags
//  rsp_valid  out  1           response held until accepted
//  rsp_ready  in   1           response consumer ready
//  rsp_res    out  WIDTH+1     captured RES
//  rsp_flags  out  6           captured {ERR,OFLOW,COUT,G,L,E}
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  Reset (RST=0, async):
//   - State forced to IDLE.
//   - CE=0, INP_VALID=2'b00, MODE/CMD/OPA/OPB/CIN=0.
//   - rsp_valid=0, rsp_res=0, rsp_flags=0, busy=0.
//   - A transaction in flight is dropped; no response is produced for it.
//  FSM: IDLE -> ISSUE_A -> [ISSUE_B] -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - req_ready=1; all ALU pins hold the reset values.
//   - Handshake (req_valid & req_ready) latches all req_* fields into holding registers.
//   - Latency value is latched: MUL_LAT if mode=1 & cmd in {9,10}, otherwise DEF_LAT.
//  ISSUE_A (1 cycle):
//   - CE=1; MODE/CMD/CIN driven from the holding registers.
//   - split=0: OPA, OPB driven, INP_VALID=11; next state WAIT.
//   - split=1: OPA driven, OPB=0, INP_VALID=01; next state ISSUE_B.
//  ISSUE_B (1 cycle):
//   - CE=1, OPB driven, OPA held, INP_VALID=10; next state WAIT.
//  WAIT:
//   - CE=1, INP_VALID=00, command fields held.
//   - Counter loads the latched latency on entry and decrements each cycle.
//   - At count 0, RES and the flags are captured into rsp_* and the FSM moves to RESP.
//   - Cycle count: handshake edge H. For split=0, capture occurs at edge H+1+LAT;
//     split=1 adds one cycle.
//  RESP:
//   - rsp_valid=1 with rsp_* stable; CE=0, INP_VALID=00.
//   - rsp_valid & rsp_ready -> IDLE on the next edge.
//   - The same-edge handshake does not accept a new request; req_ready rises in the
//     following cycle.
//  ERR is passed through as captured; the master never retries and never filters ERR.
//   - Out-of-range commands are issued unchanged.
//  req_* changes while not IDLE are ignored; holding registers are authoritative.
//  rsp_ready held low indefinitely: FSM stays in RESP; no timeout.
//  All outputs are registered; no combinational path from RES or req_* to any output.
// TESTING
//  1 ADD: mode=1, cmd=0, opa=8'hFF, opb=8'h01, cin=0, split=0
//    -> INP_VALID=11 for 1 cycle; rsp_res=9'h100, COUT=1;
//       rsp_valid rises 2 edges after handshake.
//  2 MUL: mode=1, cmd=9, opa=8'h0F, opb=8'h0F
//    -> capture 4 edges after handshake; rsp_res equals the ALU model result.
//  3 Split AND: mode=0, cmd=0, opa=8'hF0, opb=8'h3C, split=1
//    -> INP_VALID 01 then 10; rsp_res=9'h030.
//  4 Backpressure: rsp_ready=0 for 10 cycles
//    -> rsp_valid and rsp_* stable, req_ready=0;
//       after accept, req_ready=1 on the next cycle.
//  5 Async reset asserted in WAIT of a MUL (RST=0 mid-cycle)
//    -> CE=0, INP_VALID=00, busy=0 immediately; no rsp_valid after release.
//  6 Invalid: mode=0, cmd=14 -> issued unchanged; rsp_flags[5] (ERR)=1 as driven by the ALU.

Source files
------------

// File: rtl/alu_req_master_if.sv
// Bus bundle between the request/response layer, the ALU pin interface and alu_req_master.
// The master modport is the alu_req_master view; slave is the environment (stimulus + ALU).
interface alu_req_master_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4
);
    // request channel
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_mode;
    logic [CMD_WIDTH-1:0] req_cmd;
    logic [WIDTH-1:0]     req_opa;
    logic [WIDTH-1:0]     req_opb;
    logic                 req_cin;
    logic                 req_split;

    // ALU pins
    logic                 CE;
    logic                 MODE;
    logic [CMD_WIDTH-1:0] CMD;
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic                 CIN;
    logic [1:0]           INP_VALID;
    logic [WIDTH:0]       RES;
    logic                 COUT;
    logic                 OFLOW;
    logic                 ERR;
    logic                 G;
    logic                 L;
    logic                 E;

    // response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH:0]       rsp_res;
    logic [5:0]           rsp_flags;

    modport master (
        input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split,
        output req_ready,
        output CE, MODE, CMD, OPA, OPB, CIN, INP_VALID,
        input  RES, COUT, OFLOW, ERR, G, L, E,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split,
        input  req_ready,
        input  CE, MODE, CMD, OPA, OPB, CIN, INP_VALID,
        output RES, COUT, OFLOW, ERR, G, L, E,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_req_master.sv
// Initiator for the ALU pin interface: takes one request, issues it to the ALU
// (optionally as two operand beats), waits the command latency, returns RES/flags.
module alu_req_master #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned DEF_LAT   = 1,
    parameter int unsigned MUL_LAT   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    alu_req_master_if.master  bus,
    output logic              busy
);

    localparam int unsigned RES_W   = WIDTH + 1;
    localparam int unsigned MAX_LAT = (MUL_LAT > DEF_LAT) ? MUL_LAT : DEF_LAT;
    localparam int unsigned LAT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [CMD_WIDTH-1:0] CMD_MUL_A = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] CMD_MUL_B = CMD_WIDTH'(10);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_ISSUE_B = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // holding registers for the accepted request
    logic                 mode_hq,  mode_hd;
    logic [CMD_WIDTH-1:0] cmd_hq,   cmd_hd;
    logic [WIDTH-1:0]     opa_hq,   opa_hd;
    logic [WIDTH-1:0]     opb_hq,   opb_hd;
    logic                 cin_hq,   cin_hd;
    logic                 split_hq, split_hd;
    logic [LAT_W-1:0]     lat_hq,   lat_hd;
    logic [LAT_W-1:0]     cnt_q,    cnt_d;

    // registered outputs
    logic                 req_ready_q, req_ready_d;
    logic                 ce_q,        ce_d;
    logic                 mode_q,      mode_d;
    logic [CMD_WIDTH-1:0] cmd_q,       cmd_d;
    logic [WIDTH-1:0]     opa_q,       opa_d;
    logic [WIDTH-1:0]     opb_q,       opb_d;
    logic                 cin_q,       cin_d;
    logic [1:0]           inp_valid_q, inp_valid_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]     rsp_res_q,   rsp_res_d;
    logic [5:0]           rsp_flags_q, rsp_flags_d;
    logic                 busy_q,      busy_d;

    logic is_mul_c;

    // multiply variants take the long latency
    always_comb begin
        is_mul_c = bus.req_mode && ((bus.req_cmd == CMD_MUL_A) || (bus.req_cmd == CMD_MUL_B));
    end

    // next-state, holding-register and output-register computation
    always_comb begin
        state_d     = state_q;
        mode_hd     = mode_hq;
        cmd_hd      = cmd_hq;
        opa_hd      = opa_hq;
        opb_hd      = opb_hq;
        cin_hd      = cin_hq;
        split_hd    = split_hq;
        lat_hd      = lat_hq;
        cnt_d       = cnt_q;
        ce_d        = ce_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cin_d       = cin_q;
        inp_valid_d = inp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    mode_hd  = bus.req_mode;
                    cmd_hd   = bus.req_cmd;
                    opa_hd   = bus.req_opa;
                    opb_hd   = bus.req_opb;
                    cin_hd   = bus.req_cin;
                    split_hd = bus.req_split;
                    lat_hd   = is_mul_c ? LAT_W'(MUL_LAT) : LAT_W'(DEF_LAT);
                    state_d  = ST_ISSUE_A;
                end
            end
            ST_ISSUE_A: begin
                state_d = split_hq ? ST_ISSUE_B : ST_WAIT;
            end
            ST_ISSUE_B: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_res_d   = bus.RES;
                    rsp_flags_d = {bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // counter holds remaining WAIT cycles after the current one
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            cnt_d = lat_hd - LAT_W'(1);
        end

        // ALU pins follow the state being entered so they are valid in that state's cycle
        case (state_d)
            ST_IDLE: begin
                ce_d        = 1'b0;
                mode_d      = 1'b0;
                cmd_d       = '0;
                opa_d       = '0;
                opb_d       = '0;
                cin_d       = 1'b0;
                inp_valid_d = 2'b00;
            end
            ST_ISSUE_A: begin
                ce_d        = 1'b1;
                mode_d      = mode_hd;
                cmd_d       = cmd_hd;
                cin_d       = cin_hd;
                opa_d       = opa_hd;
                opb_d       = split_hd ? '0 : opb_hd;
                inp_valid_d = split_hd ? 2'b01 : 2'b11;
            end
            ST_ISSUE_B: begin
                ce_d        = 1'b1;
                opb_d       = opb_hd;
                inp_valid_d = 2'b10;
            end
            ST_WAIT: begin
                ce_d        = 1'b1;
                inp_valid_d = 2'b00;
            end
            ST_RESP: begin
                ce_d        = 1'b0;
                inp_valid_d = 2'b00;
            end
            default: begin
                ce_d        = 1'b0;
                inp_valid_d = 2'b00;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // state, holding and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            mode_hq     <= 1'b0;
            cmd_hq      <= '0;
            opa_hq      <= '0;
            opb_hq      <= '0;
            cin_hq      <= 1'b0;
            split_hq    <= 1'b0;
            lat_hq      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            ce_q        <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin_q       <= 1'b0;
            inp_valid_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_hq     <= mode_hd;
            cmd_hq      <= cmd_hd;
            opa_hq      <= opa_hd;
            opb_hq      <= opb_hd;
            cin_hq      <= cin_hd;
            split_hq    <= split_hd;
            lat_hq      <= lat_hd;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            ce_q        <= ce_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cin_q       <= cin_d;
            inp_valid_q <= inp_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.CE        = ce_q;
    assign bus.MODE      = mode_q;
    assign bus.CMD       = cmd_q;
    assign bus.OPA       = opa_q;
    assign bus.OPB       = opb_q;
    assign bus.CIN       = cin_q;
    assign bus.INP_VALID = inp_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_req_master.sv
// Directed bench for alu_req_master with a small behavioural ALU on the pin side.
module tb_alu_req_master;

    logic CLK;
    logic RST;
    logic busy;
    int   errors;
    int   checks;

    alu_req_master_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();

    alu_req_master #(
        .WIDTH(8), .CMD_WIDTH(4), .DEF_LAT(1), .MUL_LAT(3)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus.master),
        .busy (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // behavioural ALU: result follows the held pins
    logic [15:0] prod;
    always_comb begin
        prod      = 16'(bus.OPA) * 16'(bus.OPB);
        bus.RES   = 9'h000;
        bus.COUT  = 1'b0;
        bus.OFLOW = 1'b0;
        bus.ERR   = 1'b0;
        bus.G     = 1'b0;
        bus.L     = 1'b0;
        bus.E     = 1'b0;
        if (bus.MODE) begin
            case (bus.CMD)
                4'd0: begin
                    bus.RES  = {1'b0, bus.OPA} + {1'b0, bus.OPB};
                    bus.COUT = bus.RES[8];
                end
                4'd9, 4'd10: bus.RES = prod[8:0];
                default: bus.ERR = (bus.CMD > 4'd13);
            endcase
        end else begin
            case (bus.CMD)
                4'd0: bus.RES = {1'b0, bus.OPA & bus.OPB};
                4'd1: bus.RES = {1'b0, bus.OPA | bus.OPB};
                default: bus.ERR = (bus.CMD > 4'd13);
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // present a request at a negedge; returns at the negedge inside ISSUE_A
    task automatic issue(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic sp);
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_cmd   = c;
        bus.req_opa   = a;
        bus.req_opb   = b;
        bus.req_cin   = ci;
        bus.req_split = sp;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        RST           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_cmd   = 4'd0;
        bus.req_opa   = 8'h00;
        bus.req_opb   = 8'h00;
        bus.req_cin   = 1'b0;
        bus.req_split = 1'b0;
        bus.rsp_ready = 1'b1;

        // reset state
        #12;
        chk("rst_ce",        32'(bus.CE),        32'h0);
        chk("rst_inp_valid", 32'(bus.INP_VALID), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_res",   32'(bus.rsp_res),   32'h0);
        chk("rst_busy",      32'(busy),          32'h0);
        tick();
        RST = 1'b1;
        tick();
        chk("idle_req_ready", 32'(bus.req_ready), 32'h1);

        // 1: ADD FF+01, single beat, response two edges after handshake
        issue(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("t1_ce",        32'(bus.CE),        32'h1);
        chk("t1_inp_valid", 32'(bus.INP_VALID), 32'h3);
        chk("t1_opa",       32'(bus.OPA),       32'hFF);
        chk("t1_opb",       32'(bus.OPB),       32'h01);
        chk("t1_mode",      32'(bus.MODE),      32'h1);
        chk("t1_busy",      32'(busy),          32'h1);
        chk("t1_req_ready", 32'(bus.req_ready), 32'h0);
        chk("t1_rv_early",  32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t1_wait_iv",   32'(bus.INP_VALID), 32'h0);
        chk("t1_wait_ce",   32'(bus.CE),        32'h1);
        chk("t1_wait_rv",   32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_rsp_res",   32'(bus.rsp_res),   32'h100);
        chk("t1_rsp_flags", 32'(bus.rsp_flags), 32'h08);
        chk("t1_resp_ce",   32'(bus.CE),        32'h0);
        tick();
        chk("t1_done_rv",   32'(bus.rsp_valid), 32'h0);
        chk("t1_done_rdy",  32'(bus.req_ready), 32'h1);
        chk("t1_done_busy", 32'(busy),          32'h0);

        // 2: MUL 0F*0F, response four edges after handshake
        issue(1'b1, 4'd9, 8'h0F, 8'h0F, 1'b0, 1'b0);
        tick();
        tick();
        chk("t2_rv_h2", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t2_rv_h3", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t2_rv_h4",  32'(bus.rsp_valid), 32'h1);
        chk("t2_res",    32'(bus.rsp_res),   32'h0E1);
        chk("t2_flags",  32'(bus.rsp_flags), 32'h00);
        tick();
        chk("t2_done", 32'(bus.req_ready), 32'h1);

        // 3: split AND F0 & 3C, two operand beats
        issue(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0, 1'b1);
        chk("t3_iv_a",  32'(bus.INP_VALID), 32'h1);
        chk("t3_opa_a", 32'(bus.OPA),       32'hF0);
        chk("t3_opb_a", 32'(bus.OPB),       32'h00);
        tick();
        chk("t3_iv_b",  32'(bus.INP_VALID), 32'h2);
        chk("t3_opa_b", 32'(bus.OPA),       32'hF0);
        chk("t3_opb_b", 32'(bus.OPB),       32'h3C);
        chk("t3_ce_b",  32'(bus.CE),        32'h1);
        tick();
        chk("t3_wait_iv", 32'(bus.INP_VALID), 32'h0);
        chk("t3_wait_rv", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t3_rv",  32'(bus.rsp_valid), 32'h1);
        chk("t3_res", 32'(bus.rsp_res),   32'h030);
        tick();

        // 6: out-of-range command issued unchanged, ERR passed through
        issue(1'b0, 4'd14, 8'h12, 8'h34, 1'b0, 1'b0);
        chk("t6_cmd",  32'(bus.CMD),  32'hE);
        chk("t6_mode", 32'(bus.MODE), 32'h0);
        tick();
        tick();
        chk("t6_rv",    32'(bus.rsp_valid), 32'h1);
        chk("t6_flags", 32'(bus.rsp_flags), 32'h20);
        tick();

        // 4: backpressure, new request presented while in RESP is ignored
        bus.rsp_ready = 1'b0;
        issue(1'b1, 4'd0, 8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        tick();
        bus.req_valid = 1'b1;
        bus.req_mode  = 1'b0;
        bus.req_cmd   = 4'd1;
        bus.req_opa   = 8'h55;
        bus.req_opb   = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_rv",  32'(bus.rsp_valid), 32'h1);
            chk("t4_hold_res", 32'(bus.rsp_res),   32'h046);
            chk("t4_hold_rdy", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t4_acc_rv",   32'(bus.rsp_valid), 32'h0);
        chk("t4_acc_rdy",  32'(bus.req_ready), 32'h1);
        chk("t4_acc_busy", 32'(busy),          32'h0);
        chk("t4_acc_ce",   32'(bus.CE),        32'h0);
        bus.req_valid = 1'b0;
        tick();
        chk("t4_still_idle", 32'(busy), 32'h0);

        // 5: async reset during WAIT of a multiply drops the transaction
        issue(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 1'b0);
        tick();
        chk("t5_in_wait_ce", 32'(bus.CE), 32'h1);
        #2;
        RST = 1'b0;
        #1;
        chk("t5_rst_ce",   32'(bus.CE),        32'h0);
        chk("t5_rst_iv",   32'(bus.INP_VALID), 32'h0);
        chk("t5_rst_busy", 32'(busy),          32'h0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
            tick();
        end
        chk("t5_idle_rdy",  32'(bus.req_ready), 32'h1);
        chk("t5_idle_busy", 32'(busy),          32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
